// File: rtl/regfile_sb_pkg.sv
// Shared configuration for the register file slice: widths, x0 index and FSM state type.
package regfile_sb_pkg;

    localparam int unsigned XlenDefault = 32;
    localparam int unsigned RegAddrW    = 5;

    typedef logic [RegAddrW-1:0] reg_addr_t;

    localparam reg_addr_t RegX0 = '0;

    typedef enum logic {StClear, StRun} rf_state_e;

    // True for an architectural register that can hold state (not x0, inside the array).
    function automatic logic reg_valid(input reg_addr_t a, input int unsigned nregs);
        return (a != RegX0) && (32'(a) < nregs);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write counters and the source-operand hazard compare.
module regs_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS        = 32,
    parameter int unsigned PASS_THROUGH = 1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_ce,
    input  logic      i_flush,
    input  logic      i_issue,
    input  reg_addr_t i_issue_rd,
    input  logic      i_we,
    input  reg_addr_t i_addr_wr,
    input  logic      i_hz_rs1,
    input  reg_addr_t i_addr_rs1,
    input  logic      i_hz_rs2,
    input  reg_addr_t i_addr_rs2,
    output logic      o_hz
);

    localparam int unsigned IdxW = $clog2(NREGS);

    logic [1:0] pend_q [NREGS];
    logic [1:0] pend_d [NREGS];
    logic       inc, dec;

    always_comb begin
        pend_d = pend_q;
        inc    = i_ce & i_issue & reg_valid(i_issue_rd, NREGS);
        dec    = i_ce & i_we & reg_valid(i_addr_wr, NREGS);
        if (i_flush) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                pend_d[i] = '0;
            end
        end else if (!(inc && dec && (i_issue_rd == i_addr_wr))) begin
            if (inc && (pend_q[i_issue_rd[IdxW-1:0]] != 2'd3)) begin
                pend_d[i_issue_rd[IdxW-1:0]] = pend_q[i_issue_rd[IdxW-1:0]] + 2'd1;
            end
            if (dec && (pend_q[i_addr_wr[IdxW-1:0]] != 2'd0)) begin
                pend_d[i_addr_wr[IdxW-1:0]] = pend_q[i_addr_wr[IdxW-1:0]] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    // A single outstanding write landing this cycle is forwarded, so it need not stall.
    function automatic logic src_hz(input logic used, input reg_addr_t a, input logic [1:0] p,
                                    input logic we, input reg_addr_t wa);
        return used && (p != 2'd0) &&
               !((PASS_THROUGH != 0) && (p == 2'd1) && we && (wa == a));
    endfunction

    always_comb begin
        o_hz = src_hz(i_hz_rs1 & reg_valid(i_addr_rs1, NREGS),
                      i_addr_rs1, pend_q[i_addr_rs1[IdxW-1:0]], i_we, i_addr_wr) |
               src_hz(i_hz_rs2 & reg_valid(i_addr_rs2, NREGS),
                      i_addr_rs2, pend_q[i_addr_rs2[IdxW-1:0]], i_we, i_addr_wr);
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with registered reads, write bypass, post-reset clear FSM and scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN           = XlenDefault,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned PASS_THROUGH   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ce,
    input  reg_addr_t       i_addr_rd_a,
    input  reg_addr_t       i_addr_rd_b,
    input  logic            i_hz_rs1,
    input  logic            i_hz_rs2,
    input  logic            i_issue,
    input  reg_addr_t       i_issue_rd,
    input  logic            i_we,
    input  reg_addr_t       i_addr_wr,
    input  logic [XLEN-1:0] i_dat_wr,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_dat_rd_a,
    output logic [XLEN-1:0] o_dat_rd_b,
    output logic            o_hz_data,
    output logic            o_ill_reg,
    output logic            o_init_busy
);

    localparam int unsigned    IdxW    = $clog2(NREGS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NREGS - 1);

    rf_state_e       state_q;
    logic [IdxW-1:0] cnt_q;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic            wr_en, sb_hz;

    assign wr_en = i_ce & i_we & (state_q == StRun) & reg_valid(i_addr_wr, NREGS);

    function automatic logic [XLEN-1:0] read_port(input reg_addr_t a, input logic [XLEN-1:0] m,
                                                  input logic wen, input reg_addr_t wa,
                                                  input logic [XLEN-1:0] wd);
        if (!reg_valid(a, NREGS)) begin
            return '0;
        end
        if ((PASS_THROUGH != 0) && wen && (wa == a)) begin
            return wd;
        end
        return m;
    endfunction

    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (i_ce) begin
            rd_a_d = read_port(i_addr_rd_a, mem_q[i_addr_rd_a[IdxW-1:0]], wr_en, i_addr_wr,
                               i_dat_wr);
            rd_b_d = read_port(i_addr_rd_b, mem_q[i_addr_rd_b[IdxW-1:0]], wr_en, i_addr_wr,
                               i_dat_wr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            cnt_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            if (state_q == StClear) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_q <= StRun;
                end
            end
        end
    end

    // The array itself is not reset; the clear FSM zeroes it one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_q == StClear) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[i_addr_wr[IdxW-1:0]] <= i_dat_wr;
            end
        end
    end

    regs_scoreboard #(
        .NREGS        (NREGS),
        .PASS_THROUGH (PASS_THROUGH)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ce       (i_ce),
        .i_flush    (i_flush),
        .i_issue    (i_issue),
        .i_issue_rd (i_issue_rd),
        .i_we       (i_we),
        .i_addr_wr  (i_addr_wr),
        .i_hz_rs1   (i_hz_rs1),
        .i_addr_rs1 (i_addr_rd_a),
        .i_hz_rs2   (i_hz_rs2),
        .i_addr_rs2 (i_addr_rd_b),
        .o_hz       (sb_hz)
    );

    assign o_dat_rd_a  = rd_a_q;
    assign o_dat_rd_b  = rd_b_q;
    assign o_init_busy = (state_q == StClear);
    assign o_hz_data   = o_init_busy | sb_hz;
    assign o_ill_reg   = (NREGS == 16) && ((i_hz_rs1 && i_addr_rd_a[RegAddrW-1]) ||
                                           (i_hz_rs2 && i_addr_rd_b[RegAddrW-1]) ||
                                           (i_issue && i_issue_rd[RegAddrW-1]));

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array/counter model, plus directed pins.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: defaults (32 regs, bypass on, clear on reset)
    logic        rst = 1'b0, ce = 1'b0, hz1 = 1'b0, hz2 = 1'b0, issue = 1'b0, we = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  ra = '0, rb = '0, ird = '0, wa = '0;
    logic [31:0] wd = '0;
    logic [31:0] dat_a, dat_b;
    logic        hz, ill, busy;

    regfile_sb u_dut (
        .i_clk (clk), .i_rst (rst), .i_ce (ce),
        .i_addr_rd_a (ra), .i_addr_rd_b (rb), .i_hz_rs1 (hz1), .i_hz_rs2 (hz2),
        .i_issue (issue), .i_issue_rd (ird), .i_we (we), .i_addr_wr (wa), .i_dat_wr (wd),
        .i_flush (flush), .o_dat_rd_a (dat_a), .o_dat_rd_b (dat_b), .o_hz_data (hz),
        .o_ill_reg (ill), .o_init_busy (busy)
    );

    // Second DUT: 16 regs, bypass off
    logic        s_rst = 1'b0, s_ce = 1'b0, s_hz1 = 1'b0, s_hz2 = 1'b0, s_issue = 1'b0;
    logic        s_we = 1'b0, s_flush = 1'b0;
    logic [4:0]  s_ra = '0, s_rb = '0, s_ird = '0, s_wa = '0;
    logic [31:0] s_wd = '0;
    logic [31:0] s_dat_a, s_dat_b;
    logic        s_hz, s_ill, s_busy;

    regfile_sb #(.NREGS (16), .PASS_THROUGH (0)) u_dut16 (
        .i_clk (clk), .i_rst (s_rst), .i_ce (s_ce),
        .i_addr_rd_a (s_ra), .i_addr_rd_b (s_rb), .i_hz_rs1 (s_hz1), .i_hz_rs2 (s_hz2),
        .i_issue (s_issue), .i_issue_rd (s_ird), .i_we (s_we), .i_addr_wr (s_wa),
        .i_dat_wr (s_wd), .i_flush (s_flush), .o_dat_rd_a (s_dat_a), .o_dat_rd_b (s_dat_b),
        .o_hz_data (s_hz), .o_ill_reg (s_ill), .o_init_busy (s_busy)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model of the default-parameter DUT
    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic [31:0] m_rd_a, m_rd_b;
    bit          m_busy;
    int          m_idx;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_src_stall(input bit used, input logic [4:0] s);
        if (!used || s == 0 || m_pend[s] == 0) return 1'b0;
        return !(m_pend[s] == 1 && we && wa == s);
    endfunction

    function automatic bit m_hz();
        return m_busy || m_src_stall(hz1, ra) || m_src_stall(hz2, rb);
    endfunction

    task automatic compare();
        chk("rd_a", dat_a, m_rd_a);
        chk("rd_b", dat_b, m_rd_b);
        chk("hz_data", 32'(hz), 32'(m_hz()));
        chk("init_busy", 32'(busy), 32'(m_busy));
        chk("ill_reg", 32'(ill), 32'd0);
    endtask

    task automatic model_step();
        bit wr, inc, dec;
        if (rst) begin
            m_rd_a = '0;
            m_rd_b = '0;
            foreach (m_pend[i]) m_pend[i] = 0;
            m_busy = 1'b1;
            m_idx  = 0;
            return;
        end
        wr = !m_busy && ce && we && wa != 0;
        if (ce) begin
            m_rd_a = (ra == 0) ? 32'd0 : (wr && wa == ra) ? wd : m_regs[ra];
            m_rd_b = (rb == 0) ? 32'd0 : (wr && wa == rb) ? wd : m_regs[rb];
        end
        if (m_busy) begin
            m_regs[m_idx] = '0;
            m_idx++;
            if (m_idx == 32) m_busy = 1'b0;
        end
        if (wr) m_regs[wa] = wd;
        if (flush) begin
            foreach (m_pend[i]) m_pend[i] = 0;
        end else if (ce) begin
            inc = issue && ird != 0;
            dec = we && wa != 0;
            if (!(inc && dec && ird == wa)) begin
                if (inc && m_pend[ird] < 3) m_pend[ird]++;
                if (dec && m_pend[wa] > 0) m_pend[wa]--;
            end
        end
    endtask

    // One clock: inputs already applied at the falling edge.
    task automatic cycle();
        #1;
        if (cmp_en) compare();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        ce = 1'b0; hz1 = 1'b0; hz2 = 1'b0; issue = 1'b0; we = 1'b0; flush = 1'b0;
        ra = '0; rb = '0; ird = '0; wa = '0; wd = '0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic count_busy_main(input string name);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            cycle();
        end
        chk(name, 32'(n), 32'd32);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 'x;
        m_rd_a = '0; m_rd_b = '0; m_busy = 1'b1; m_idx = 0;
        foreach (m_pend[i]) m_pend[i] = 0;

        @(negedge clk);
        rst = 1'b1;
        cycle();
        cmp_en = 1'b1;
        cycle();
        chk("reset_rd_a", dat_a, 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_hz", 32'(hz), 32'd1);
        rst = 1'b0;
        count_busy_main("clear_len_32");

        ce = 1'b1;
        for (int i = 1; i < 32; i++) begin
            ra = 5'(i);
            rb = 5'(31 - i);
            cycle();
            chk("cleared_read", dat_a, 32'd0);
        end

        // Write-through on x5
        idle();
        ce = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = 5'd5;
        cycle();
        chk("bypass_x5", dat_a, 32'hDEADBEEF);

        // Two issues to x7, then two writebacks
        idle();
        ce = 1'b1; issue = 1'b1; ird = 5'd7;
        cycle();
        cycle();
        issue = 1'b0; hz1 = 1'b1; ra = 5'd7;
        #1 chk("x7_pend2", 32'(hz), 32'd1);
        cycle();
        we = 1'b1; wa = 5'd7; wd = 32'h11;
        #1 chk("x7_first_wb", 32'(hz), 32'd1);
        cycle();
        we = 1'b0;
        #1 chk("x7_pend1", 32'(hz), 32'd1);
        cycle();
        we = 1'b1; wd = 32'h22;
        #1 chk("x7_second_wb", 32'(hz), 32'd0);
        cycle();
        we = 1'b0;
        #1 chk("x7_done", 32'(hz), 32'd0);
        cycle();

        // Flush clears pending x3; later writeback still lands
        idle();
        ce = 1'b1; issue = 1'b1; ird = 5'd3;
        cycle();
        issue = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0; hz1 = 1'b1; ra = 5'd3;
        #1 chk("flush_hz", 32'(hz), 32'd0);
        we = 1'b1; wa = 5'd3; wd = 32'h12345678;
        cycle();
        we = 1'b0;
        cycle();
        chk("flush_wb_data", dat_a, 32'h12345678);
        #1 chk("flush_cnt_zero", 32'(hz), 32'd0);

        // Reset mid-clear at index 10
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_busy_main("clear_restart_32");

        repeat (3000) begin
            rst   = ($urandom_range(0, 199) == 0);
            ce    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            issue = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            hz1   = 1'($urandom_range(0, 1));
            hz2   = 1'($urandom_range(0, 1));
            ra    = rnd_addr();
            rb    = rnd_addr();
            ird   = rnd_addr();
            wa    = rnd_addr();
            wd    = $urandom;
            cycle();
        end
        idle();
        rst = 1'b0;

        // 16-register, no-bypass instance
        begin
            int n = 0;
            s_rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("s_reset_rd", s_dat_a, 32'd0);
            chk("s_reset_busy", 32'(s_busy), 32'd1);
            chk("s_reset_hz", 32'(s_hz), 32'd1);
            s_rst = 1'b0;
            while (s_busy && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("s_clear_len_16", 32'(n), 32'd16);
        end
        s_hz2 = 1'b1; s_rb = 5'd20;
        #1 chk("s_ill_rs2", 32'(s_ill), 32'd1);
        s_hz2 = 1'b0;
        #1 chk("s_ill_unused", 32'(s_ill), 32'd0);
        s_issue = 1'b1; s_ird = 5'd17;
        #1 chk("s_ill_issue", 32'(s_ill), 32'd1);
        s_issue = 1'b0; s_hz1 = 1'b1; s_ra = 5'd4;
        #1 chk("s_ill_legal", 32'(s_ill), 32'd0);

        s_hz1 = 1'b0; s_ce = 1'b1; s_we = 1'b1; s_wa = 5'd4; s_wd = 32'h0000AAAA;
        @(negedge clk);
        s_wa = 5'd20; s_wd = 32'h00005555;
        @(negedge clk);
        s_we = 1'b0;
        @(negedge clk);
        #1 chk("s_x20_ignored", s_dat_a, 32'h0000AAAA);

        s_we = 1'b1; s_wa = 5'd5; s_wd = 32'hDEADBEEF; s_ra = 5'd5;
        @(negedge clk);
        s_we = 1'b0;
        #1 chk("s_old_value", s_dat_a, 32'd0);
        @(negedge clk);
        #1 chk("s_new_value", s_dat_a, 32'hDEADBEEF);

        s_issue = 1'b1; s_ird = 5'd6;
        @(negedge clk);
        s_issue = 1'b0; s_hz1 = 1'b1; s_ra = 5'd6; s_we = 1'b1; s_wa = 5'd6;
        #1 chk("s_no_bypass_hz", 32'(s_hz), 32'd1);
        @(negedge clk);
        s_we = 1'b0;
        #1 chk("s_hz_cleared", 32'(s_hz), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
